// File: rtl/seg_msg_sequencer.sv
// Seven-segment message sequencer: steps a writable glyph buffer out to one digit
// at a programmable rate, with loop / one-shot / bounce / hold playback modes.
module seg_msg_sequencer #(
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    output logic [7:0]        seg_out,
    output logic [ADDR_W-1:0] cur_idx,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_LOOP    = 2'd0;
    localparam logic [1:0] M_ONESHOT = 2'd1;
    localparam logic [1:0] M_BOUNCE  = 2'd2;

    logic [1:0]        state;
    logic [DIV_W-1:0]  presc;
    logic              dir_down;
    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] nxt_idx;
    logic              nxt_dir;
    logic              nxt_wrap;
    logic              nxt_done;
    logic              at_end;
    logic              tick;

    assign busy   = (state == S_RUN);
    // >= rather than == so a div lowered mid-count cannot strand the prescaler
    assign tick   = (state == S_RUN) && (presc >= div);
    assign at_end = (cur_idx >= last_idx);

    always_comb begin
        nxt_idx  = cur_idx;
        nxt_dir  = dir_down;
        nxt_wrap = 1'b0;
        nxt_done = 1'b0;
        case (mode)
            M_LOOP: begin
                if (at_end) begin
                    nxt_idx  = '0;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_idx = cur_idx + 1'b1;
                end
            end
            M_ONESHOT: begin
                if (at_end) nxt_done = 1'b1;
                else        nxt_idx  = cur_idx + 1'b1;
            end
            M_BOUNCE: begin
                // single-glyph message has nowhere to bounce to
                if (last_idx == '0) begin
                    nxt_idx  = '0;
                    nxt_wrap = 1'b1;
                end else if (!dir_down) begin
                    if (at_end) begin
                        nxt_dir  = 1'b1;
                        nxt_idx  = cur_idx - 1'b1;
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_idx = cur_idx + 1'b1;
                    end
                end else begin
                    if (cur_idx == '0) begin
                        nxt_dir  = 1'b0;
                        nxt_idx  = cur_idx + 1'b1;
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_idx = cur_idx - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            dir_down <= 1'b0;
            cur_idx  <= '0;
            seg_out  <= 8'h00;
            wrap     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            seg_out <= (state == S_IDLE) ? 8'h00 : mem[cur_idx];
            wrap    <= 1'b0;
            done    <= 1'b0;
            if (stop || start) begin
                state    <= stop ? S_IDLE : S_RUN;
                cur_idx  <= '0;
                presc    <= '0;
                dir_down <= 1'b0;
            end else if (state == S_RUN) begin
                if (tick) begin
                    presc    <= '0;
                    cur_idx  <= nxt_idx;
                    dir_down <= nxt_dir;
                    wrap     <= nxt_wrap;
                    done     <= nxt_done;
                    if (nxt_done) state <= S_DONE;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule
